// File: rtl/fp_accum_ctrl.sv
// -----------------------------------------------------------------------------
// fp_accum_ctrl
// Sequences a stream of IEEE-754 single-precision elements through an external
// floating-point add/sub unit and accumulates the running result. The block
// does no arithmetic on the data. The accumulator only ever takes an element
// verbatim (the first element of a stream) or the unit's add_result.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : element handshake; transfer when both are 1
//   in_data             : element (fp32)
//   in_sub              : subtract this element (ignored on first element)
//   in_last             : element closes the stream
//   add_start           : one-cycle request to the FP unit
//   mode, op1, op2      : operation select, accumulator, element to the unit
//   add_result/add_done : unit result and its qualifier
//   add_overflow        : unit overflow flag, meaningful with add_done
//   sum_valid/sum_ready : result handshake; outputs are held until accepted
//   sum_data            : accumulated value
//   sum_overflow        : any unit overflow seen during the stream
//   sum_timeout         : the stream was cut short by a unit timeout
//   sum_count           : elements consumed (saturating)
//   dbg_state_o         : FSM state (0 IDLE, 1 LOAD, 2 ISSUE, 3 WAIT, 4 OUT)
//
// Handshake semantics: a transfer occurs on a rising edge where valid and
// ready are both 1. valid-side outputs (sum_*) stay stable while
// sum_valid=1 and sum_ready=0. ready is never a function of valid.
// -----------------------------------------------------------------------------
module fp_accum_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   input  logic             in_sub,
   input  logic             in_last,
   output logic             in_ready,
   output logic             add_start,
   output logic             mode,
   output logic [31:0]      op1,
   output logic [31:0]      op2,
   input  logic [31:0]      add_result,
   input  logic             add_done,
   input  logic             add_overflow,
   output logic             sum_valid,
   input  logic             sum_ready,
   output logic [31:0]      sum_data,
   output logic             sum_overflow,
   output logic             sum_timeout,
   output logic [CNT_W-1:0] sum_count,
   output logic [2:0]       dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4
   } state_t;

   // The timer counts completed WAIT cycles (0 .. TIMEOUT-1). Seeing
   // TIMEOUT-1 in a WAIT cycle with no add_done means that cycle is the
   // TIMEOUT-th one, so the wait gives up at the end of it.
   localparam int TMR_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [31:0]      acc_q, acc_d;
   logic [31:0]      opnd_q, opnd_d;
   logic             op_sub_q, op_sub_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             ovf_q, ovf_d;
   logic             tmo_q, tmo_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_sub_q <= 1'b0;
         last_q   <= 1'b0;
         count_q  <= '0;
         timer_q  <= '0;
         ovf_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_sub_q <= op_sub_d;
         last_q   <= last_d;
         count_q  <= count_d;
         timer_q  <= timer_d;
         ovf_q    <= ovf_d;
         tmo_q    <= tmo_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      opnd_d       = opnd_q;
      op_sub_d     = op_sub_q;
      last_d       = last_q;
      count_d      = count_q;
      timer_d      = timer_q;
      ovf_d        = ovf_q;
      tmo_d        = tmo_q;
      in_ready     = 1'b0;
      add_start    = 1'b0;
      mode         = 1'b0;
      op1          = '0;
      op2          = '0;
      sum_valid    = 1'b0;
      sum_data     = '0;
      sum_overflow = 1'b0;
      sum_timeout  = 1'b0;
      sum_count    = '0;

      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // First element seeds the accumulator; in_sub is irrelevant.
               acc_d   = in_data;
               count_d = CNT_W'(1);
               ovf_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = in_last ? S_OUT : S_LOAD;
            end
         end

         S_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               opnd_d   = in_data;
               op_sub_d = in_sub;
               last_d   = in_last;
               count_d  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
               state_d  = S_ISSUE;
            end
         end

         S_ISSUE: begin
            add_start = 1'b1;
            mode      = op_sub_q;
            op1       = acc_q;
            op2       = opnd_q;
            timer_d   = '0;
            state_d   = S_WAIT;
         end

         S_WAIT: begin
            // Operands stay on the bus until the unit answers or we give up.
            mode = op_sub_q;
            op1  = acc_q;
            op2  = opnd_q;
            // add_done is checked first, so a done in the final timer cycle wins.
            if (add_done) begin
               acc_d   = add_result;
               ovf_d   = ovf_q | add_overflow;
               state_d = last_q ? S_OUT : S_LOAD;
            end else if (timer_q == TMR_LAST) begin
               tmo_d   = 1'b1;
               state_d = S_OUT;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end

         S_OUT: begin
            sum_valid    = 1'b1;
            sum_data     = acc_q;
            sum_overflow = ovf_q;
            sum_timeout  = tmo_q;
            sum_count    = count_q;
            if (sum_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fp_accum_ctrl
// Bench for fp_accum_ctrl with TIMEOUT=4. A responder plays the FP unit with
// a programmable latency (0 = never answers). Expected results are pushed to
// exp_q when a stream is driven and compared when sum_valid/sum_ready fire.
// -----------------------------------------------------------------------------
module tb_fp_accum_ctrl;

   localparam int TMO = 4;
   localparam int CW  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          in_valid, in_sub, in_last, in_ready;
   logic [31:0]   in_data;
   logic          add_start, mode, add_done, add_overflow;
   logic [31:0]   op1, op2, add_result;
   logic          sum_valid, sum_ready, sum_overflow, sum_timeout;
   logic [31:0]   sum_data;
   logic [CW-1:0] sum_count;
   logic [2:0]    dbg_state;

   fp_accum_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_sub(in_sub), .in_last(in_last),
      .in_ready(in_ready),
      .add_start(add_start), .mode(mode), .op1(op1), .op2(op2),
      .add_result(add_result), .add_done(add_done), .add_overflow(add_overflow),
      .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
      .sum_overflow(sum_overflow), .sum_timeout(sum_timeout), .sum_count(sum_count),
      .dbg_state_o(dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int          errors = 0;
   int          checks = 0;
   logic [49:0] exp_q[$];
   logic [31:0] st_d[$];
   logic        st_s[$];
   int          resp_lat    = 1;
   logic        resp_ovf    = 1'b0;
   logic        inject_done = 1'b0;
   logic        hold_ready  = 1'b0;
   int          n_starts    = 0;
   logic        last_mode   = 1'b0;
   logic [64:0] held_ops    = '0;

   task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [49:0] mk(input logic ovf, input logic tmo,
                                      input int cnt, input logic [31:0] d);
      return {ovf, tmo, CW'(cnt), d};
   endfunction

   // Exact fp32 encode/decode for small integers (|v| < 2^24).
   function automatic logic [31:0] int_to_fp(input int v);
      int m;
      int p;
      logic [31:0] r;
      if (v == 0) return 32'h0;
      m = (v < 0) ? -v : v;
      p = 0;
      for (int i = 0; i < 24; i++) if (((m >> i) & 1) != 0) p = i;
      r[31]    = (v < 0);
      r[30:23] = 8'(127 + p);
      r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
      return r;
   endfunction

   function automatic int fp_to_int(input logic [31:0] b);
      int e;
      int m;
      e = int'(b[30:23]);
      if (e == 0) return 0;
      m = int'({1'b1, b[22:0]}) >> (23 - (e - 127));
      return b[31] ? -m : m;
   endfunction

   // ---------------- FP unit responder ----------------
   initial begin
      logic [31:0] ra, rb;
      logic        rm, pend;
      int          wcnt;
      ra = '0; rb = '0; rm = 1'b0; pend = 1'b0; wcnt = 0;
      add_done = 1'b0; add_result = '0; add_overflow = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         add_done     = 1'b0;
         add_overflow = 1'b0;
         if (rst) begin
            pend = 1'b0;
         end else if (inject_done) begin
            add_done     = 1'b1;
            add_result   = 32'h4F00_0000;
            add_overflow = 1'b1;
         end else if (add_start) begin
            pend = 1'b1; wcnt = 0; ra = op1; rb = op2; rm = mode;
         end else if (pend) begin
            wcnt++;
            if (resp_lat != 0 && wcnt == resp_lat) begin
               add_done     = 1'b1;
               add_overflow = resp_ovf;
               add_result   = int_to_fp(rm ? fp_to_int(ra) - fp_to_int(rb)
                                           : fp_to_int(ra) + fp_to_int(rb));
               pend = 1'b0;
            end
         end
      end
   end

   // ---------------- result sink ----------------
   initial begin
      sum_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         sum_ready = !hold_ready;
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (add_start) begin
            n_starts++;
            held_ops  = {mode, op1, op2};
            last_mode = mode;
         end else if (dbg_state == 3'd3) begin
            check("op_hold", {mode, op1, op2}, held_ops);
         end else if (dbg_state != 3'd2) begin
            check("op_zero", {mode, op1, op2}, '0);
         end
         if (sum_valid && sum_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_sum", {sum_overflow, sum_timeout, sum_count, sum_data}, '0);
            end else begin
               logic [49:0] e;
               e = exp_q.pop_front();
               check("sum", {sum_overflow, sum_timeout, sum_count, sum_data}, e);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input logic [31:0] d, input logic sub, input logic last);
      in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
            return;
         end
      end
      check("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic add_el(input logic [31:0] d, input logic s);
      st_d.push_back(d);
      st_s.push_back(s);
   endtask

   // Drives st_d/st_s as one stream (in_last on the final element).
   task automatic drive_stream(input logic [49:0] e, input int exp_starts);
      int s0;
      s0 = n_starts;
      exp_q.push_back(e);
      for (int i = 0; i < st_d.size(); i++) send(st_d[i], st_s[i], i == st_d.size() - 1);
      drain();
      check("start_count", n_starts - s0, exp_starts);
      st_d.delete();
      st_s.delete();
   endtask

   task automatic wait_sum_valid(input string tag);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sum_valid) return;
      end
      check(tag, sum_valid, 1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int k;
      int n;
      int acc;
      int v;
      logic s;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sub = 1'b0; in_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset values
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_add_start", add_start, 0);
      check("rst_ops", {mode, op1, op2}, '0);
      check("rst_sum", {sum_valid, sum_overflow, sum_timeout, sum_count, sum_data}, '0);
      @(posedge clk);
      #1;

      // single element
      add_el(32'h3F80_0000, 1'b0);
      drive_stream(mk(0, 0, 1, 32'h3F80_0000), 0);

      // 1 + 2 + 3, latency 1
      resp_lat = 1;
      add_el(32'h3F80_0000, 1'b0);
      add_el(32'h4000_0000, 1'b0);
      add_el(32'h4040_0000, 1'b0);
      drive_stream(mk(0, 0, 3, 32'h40C0_0000), 2);

      // 3 - 1
      add_el(32'h4040_0000, 1'b0);
      add_el(32'h3F80_0000, 1'b1);
      drive_stream(mk(0, 0, 2, 32'h4000_0000), 1);
      check("mode_sub", last_mode, 1);

      // in_sub on the first element is ignored: 2 + 1 = 3
      add_el(32'h4000_0000, 1'b1);
      add_el(32'h3F80_0000, 1'b0);
      drive_stream(mk(0, 0, 2, 32'h4040_0000), 1);
      check("mode_add", last_mode, 0);

      // timeout: unit never answers, 4 WAIT cycles then OUT
      resp_lat = 0;
      exp_q.push_back(mk(0, 1, 2, 32'h40A0_0000));
      send(32'h40A0_0000, 1'b0, 1'b0);
      send(32'h3F80_0000, 1'b0, 1'b1);
      k = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (sum_valid) break;
         k++;
      end
      check("tmo_latency", k, 5);
      drain();

      // timeout mid-stream: the rest becomes a new stream
      exp_q.push_back(mk(0, 1, 2, 32'h4100_0000));
      add_el(32'h4100_0000, 1'b0);
      add_el(32'h3F80_0000, 1'b0);
      add_el(32'h4080_0000, 1'b0);
      drive_stream(mk(0, 0, 1, 32'h4080_0000), 1);

      // done on the final timer cycle wins
      resp_lat = 4;
      add_el(32'h3F80_0000, 1'b0);
      add_el(32'h4000_0000, 1'b0);
      drive_stream(mk(0, 0, 2, 32'h4040_0000), 1);

      // overflow is sticky within a stream and cleared by the next one
      resp_lat = 2; resp_ovf = 1'b1;
      add_el(32'h3F80_0000, 1'b0);
      add_el(32'h4000_0000, 1'b0);
      drive_stream(mk(1, 0, 2, 32'h4040_0000), 1);
      resp_ovf = 1'b0;
      add_el(32'h4080_0000, 1'b0);
      drive_stream(mk(0, 0, 1, 32'h4080_0000), 0);

      // back-pressure on the result
      hold_ready = 1'b1;
      exp_q.push_back(mk(0, 0, 1, 32'h4120_0000));
      send(32'h4120_0000, 1'b0, 1'b1);
      wait_sum_valid("hold_wait");
      for (int i = 0; i < 5; i++) begin
         check("hold_data", {sum_valid, sum_count, sum_data}, {1'b1, CW'(1), 32'h4120_0000});
         check("hold_in_ready", in_ready, 0);
         if (i < 4) @(negedge clk);
      end
      hold_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("post_hs_in_ready", in_ready, 1);
      check("post_hs_sum_valid", sum_valid, 0);
      check("post_hs_queue", exp_q.size(), 0);
      @(posedge clk);
      #1;

      // reset during WAIT, then a late add_done
      resp_lat = 0;
      send(32'h4000_0000, 1'b0, 1'b0);
      send(32'h4040_0000, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      check("in_wait", dbg_state, 3'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      inject_done = 1'b1;
      @(negedge clk);
      check("rst_wait_state", dbg_state, 3'd0);
      check("rst_wait_in_ready", in_ready, 1);
      check("rst_wait_outs", {add_start, mode, op1, op2}, '0);
      check("rst_wait_sum", {sum_valid, sum_overflow, sum_timeout, sum_count, sum_data}, '0);
      @(posedge clk);
      #1;
      inject_done = 1'b0;
      @(negedge clk);
      check("late_done_state", dbg_state, 3'd0);
      check("late_done_sum_valid", sum_valid, 0);
      @(posedge clk);
      #1;
      add_el(32'h40E0_0000, 1'b0);
      drive_stream(mk(0, 0, 1, 32'h40E0_0000), 0);

      // random streams of small integers
      for (int t = 0; t < 15; t++) begin
         n        = $urandom_range(1, 4);
         resp_lat = $urandom_range(1, 4);
         resp_ovf = 1'($urandom_range(0, 1));
         acc      = 0;
         for (int j = 0; j < n; j++) begin
            v = $urandom_range(1, 20);
            s = 1'($urandom_range(0, 1));
            if (j == 0) acc = v;
            else acc = s ? acc - v : acc + v;
            add_el(int_to_fp(v), s);
         end
         drive_stream(mk(resp_ovf && n > 1, 0, n, int_to_fp(acc)), n - 1);
      end
      resp_ovf = 1'b0;

      check("final_queue", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
